// File: rtl/pdp8_mem_pkg.sv
// pdp8_mem_pkg
// Shared definitions for the PDP-8 memory arbiter: default bus widths,
// arbiter FSM state encoding, requester (owner) encoding and request-vector
// bit positions.
package pdp8_mem_pkg;

    localparam int ADDR_W_DEF = 15;   // 8 fields x 4K words
    localparam int DATA_W_DEF = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    // Bit positions inside the two-entry request and mask vectors
    localparam int REQ_CPU = 0;
    localparam int REQ_DMA = 1;

    // One-hot mask bit for an owner, laid out like the request vector
    function automatic logic [1:0] owner_onehot(input logic owner);
        return (owner == OWN_DMA) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/pdp8_mem_arb_pick.sv
// pdp8_mem_arb_pick
// Combinational grant selection between the CPU and the data-break channel.
// Optional macro: PDP8_ARB_FAIR_EN selects alternating priority on a tie
// (the requester not served last wins); otherwise DMA always wins a tie.
// Ports:
//   cpu_req, dma_req  in   already-masked requests
//   last_owner        in   owner of the previous grant (PDP8_ARB_FAIR_EN only)
//   grant_valid       out  some requester is granted
//   grant_owner       out  granted requester (OWN_CPU / OWN_DMA)
module pdp8_mem_arb_pick
    import pdp8_mem_pkg::*;
(
    input  logic cpu_req,
    input  logic dma_req,
`ifdef PDP8_ARB_FAIR_EN
    input  logic last_owner,
`endif
    output logic grant_valid,
    output logic grant_owner
);

    always_comb begin
        grant_valid = cpu_req | dma_req;
        grant_owner = OWN_CPU;
        if (dma_req) begin
            grant_owner = OWN_DMA;
        end
`ifdef PDP8_ARB_FAIR_EN
        // Tie: hand the port to whoever did not have it last time
        if (cpu_req && dma_req) begin
            grant_owner = (last_owner == OWN_CPU) ? OWN_DMA : OWN_CPU;
        end
`endif
    end

endmodule

// File: rtl/pdp8_mem_arbiter.sv
// pdp8_mem_arbiter
// Shares the single pdp8_ram port between the CPU and the I/O data-break
// (DMA) channel. Each access is a fixed ACCESS_CYCLES-long strobe window
// driven from latched registers, followed by a one-cycle completion pulse.
// Optional macro: PDP8_ARB_FAIR_EN (alternating tie priority with a
// last_owner register); undefined gives fixed DMA priority.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata          CPU request and qualifiers
//   cpu_rdata, cpu_ack             CPU read data and completion pulse
//   dma_read_req/write_req/ma/in   DMA requests and qualifiers
//   dma_out, dma_done              DMA read data and completion pulse
//   ram_addr/data_in/rd/wr         to pdp8_ram
//   ram_data_out                   from pdp8_ram
module pdp8_mem_arbiter
    import pdp8_mem_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int ACCESS_CYCLES = 2            // legal range 1..15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              dma_read_req,
    input  logic              dma_write_req,
    input  logic [ADDR_W-1:0] dma_ma,
    input  logic [DATA_W-1:0] dma_in,
    output logic [DATA_W-1:0] dma_out,
    output logic              dma_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out,
    output logic              ram_rd,
    output logic              ram_wr
);

    localparam logic [3:0] CNT_LAST = 4'(ACCESS_CYCLES - 1);

    arb_state_t        state_reg, state_next;
    logic              owner_reg, owner_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic [1:0]        mask_reg, mask_next;
    logic [DATA_W-1:0] cpu_rdata_reg, cpu_rdata_next;
    logic [DATA_W-1:0] dma_out_reg, dma_out_next;

    logic [1:0]        req_raw;
    logic [1:0]        req_masked;
    logic              grant_valid;
    logic              grant_owner;

    assign req_raw[REQ_CPU] = cpu_req;
    assign req_raw[REQ_DMA] = dma_read_req | dma_write_req;

    // The requester just served is blanked for one IDLE cycle so its
    // still-high request is not mistaken for a new one.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_mask
            assign req_masked[gi] = req_raw[gi] & ~mask_reg[gi];
        end
    endgenerate

`ifdef PDP8_ARB_FAIR_EN
    logic last_owner_reg, last_owner_next;
`endif

    pdp8_mem_arb_pick u_pick (
        .cpu_req     (req_masked[REQ_CPU]),
        .dma_req     (req_masked[REQ_DMA]),
`ifdef PDP8_ARB_FAIR_EN
        .last_owner  (last_owner_reg),
`endif
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            owner_reg     <= OWN_CPU;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            cnt_reg       <= '0;
            mask_reg      <= '0;
            cpu_rdata_reg <= '0;
            dma_out_reg   <= '0;
`ifdef PDP8_ARB_FAIR_EN
            last_owner_reg <= OWN_CPU;
`endif
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            we_reg        <= we_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            cnt_reg       <= cnt_next;
            mask_reg      <= mask_next;
            cpu_rdata_reg <= cpu_rdata_next;
            dma_out_reg   <= dma_out_next;
`ifdef PDP8_ARB_FAIR_EN
            last_owner_reg <= last_owner_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        we_next        = we_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        cnt_next       = cnt_reg;
        mask_next      = 2'b00;
        cpu_rdata_next = cpu_rdata_reg;
        dma_out_next   = dma_out_reg;
`ifdef PDP8_ARB_FAIR_EN
        last_owner_next = last_owner_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    owner_next = grant_owner;
                    cnt_next   = '0;
                    state_next = ACCESS;
`ifdef PDP8_ARB_FAIR_EN
                    last_owner_next = grant_owner;
`endif
                    if (grant_owner == OWN_DMA) begin
                        // Read and write both high resolves to a write
                        we_next    = dma_write_req;
                        addr_next  = dma_ma;
                        wdata_next = dma_in;
                    end else begin
                        we_next    = cpu_we;
                        addr_next  = cpu_addr;
                        wdata_next = cpu_wdata;
                    end
                end
            end
            ACCESS: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = DONE;
                    if (!we_reg) begin
                        if (owner_reg == OWN_DMA) begin
                            dma_out_next = ram_data_out;
                        end else begin
                            cpu_rdata_next = ram_data_out;
                        end
                    end
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            DONE: begin
                mask_next  = owner_onehot(owner_reg);
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Strobes and pulses decode straight from state so reset clears them
    // the moment it is asserted.
    assign ram_rd      = (state_reg == ACCESS) && !we_reg;
    assign ram_wr      = (state_reg == ACCESS) && we_reg;
    assign cpu_ack     = (state_reg == DONE) && (owner_reg == OWN_CPU);
    assign dma_done    = (state_reg == DONE) && (owner_reg == OWN_DMA);
    assign ram_addr    = addr_reg;
    assign ram_data_in = wdata_reg;
    assign cpu_rdata   = cpu_rdata_reg;
    assign dma_out     = dma_out_reg;

endmodule

// File: tb/tb_pdp8_mem_arbiter.sv
// tb_pdp8_mem_arbiter
// Directed bench for pdp8_mem_arbiter with a registered-read RAM model.
// Honours PDP8_ARB_FAIR_EN for the tie-breaking expectations.
module tb_pdp8_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [14:0] cpu_addr = '0;
    logic [11:0] cpu_wdata = '0;
    logic [11:0] cpu_rdata;
    logic        cpu_ack;
    logic        dma_read_req = 1'b0, dma_write_req = 1'b0;
    logic [14:0] dma_ma = '0;
    logic [11:0] dma_in = '0;
    logic [11:0] dma_out;
    logic        dma_done;
    logic [14:0] ram_addr;
    logic [11:0] ram_data_in;
    logic [11:0] ram_data_out;
    logic        ram_rd, ram_wr;

    int checks = 0;
    int failures = 0;

    pdp8_mem_arbiter #(.ADDR_W(15), .DATA_W(12), .ACCESS_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dma_read_req(dma_read_req), .dma_write_req(dma_write_req),
        .dma_ma(dma_ma), .dma_in(dma_in), .dma_out(dma_out), .dma_done(dma_done),
        .ram_addr(ram_addr), .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
        .ram_rd(ram_rd), .ram_wr(ram_wr)
    );

    always #5 clk = ~clk;

    // RAM model: synchronous write, registered read, plus a bench preload port
    logic [11:0] mem [0:32767];
    logic        pre_we = 1'b0;
    logic [14:0] pre_addr = '0;
    logic [11:0] pre_data = '0;
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (ram_wr) mem[ram_addr] <= ram_data_in;
        if (ram_rd) ram_data_out <= mem[ram_addr];
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [14:0] a, input logic [11:0] d);
        pre_addr = a; pre_data = d; pre_we = 1'b1;
        cycle();
        pre_we = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
    endtask

    // One isolated access, observed for 8 cycles after the request cycle.
    task automatic run_access(input logic is_dma, input logic we, input logic both,
                              input logic [14:0] a, input logic [11:0] d,
                              output int rd_cnt, output int wr_cnt, output int ack_cnt,
                              output int ack_at, output int other_cnt, output int bad);
        rd_cnt = 0; wr_cnt = 0; ack_cnt = 0; ack_at = 0; other_cnt = 0; bad = 0;
        if (is_dma) begin
            dma_ma = a; dma_in = d;
            dma_write_req = we | both; dma_read_req = ~we | both;
        end else begin
            cpu_addr = a; cpu_wdata = d; cpu_we = we; cpu_req = 1'b1;
        end
        for (int k = 1; k <= 8; k++) begin
            cycle();
            if (ram_rd) begin
                rd_cnt++;
                if (ram_addr !== a) bad++;
            end
            if (ram_wr) begin
                wr_cnt++;
                if (ram_addr !== a || ram_data_in !== d) bad++;
            end
            if ((is_dma ? dma_done : cpu_ack) === 1'b1) begin
                ack_cnt++; ack_at = k;
                cpu_req = 1'b0; dma_read_req = 1'b0; dma_write_req = 1'b0;
            end
            if ((is_dma ? cpu_ack : dma_done) === 1'b1) other_cnt++;
        end
    endtask

    // Both requesters read in the same cycle; records when each completes.
    task automatic run_tie(output int cpu_at, output int dma_at);
        cpu_at = 0; dma_at = 0;
        cpu_addr = 15'o00500; cpu_we = 1'b0; cpu_req = 1'b1;
        dma_ma = 15'o00600; dma_read_req = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            if (cpu_ack === 1'b1) begin cpu_at = k; cpu_req = 1'b0; end
            if (dma_done === 1'b1) begin dma_at = k; dma_read_req = 1'b0; end
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        #1;
        checks++; if (ram_rd !== 1'b0) begin failures++; $display("FAIL reset_ram_rd got=%b exp=0", ram_rd); end
        checks++; if (ram_wr !== 1'b0) begin failures++; $display("FAIL reset_ram_wr got=%b exp=0", ram_wr); end
        checks++; if (cpu_ack !== 1'b0 || dma_done !== 1'b0) begin failures++; $display("FAIL reset_acks got=%b%b exp=00", cpu_ack, dma_done); end
        checks++; if (ram_addr !== 15'd0 || ram_data_in !== 12'd0) begin failures++; $display("FAIL reset_ram_bus got=%o/%o exp=0/0", ram_addr, ram_data_in); end
        checks++; if (cpu_rdata !== 12'd0 || dma_out !== 12'd0) begin failures++; $display("FAIL reset_rdata got=%o/%o exp=0/0", cpu_rdata, dma_out); end
        cycle();
        reset = 1'b0;
        cycle();
        $display("test_reset done");
    endtask

    task automatic test_cpu_read();
        int rd, wr, ac, at, oth, bad;
        preload(15'o07400, 12'o7402);
        run_access(1'b0, 1'b0, 1'b0, 15'o07400, 12'o0, rd, wr, ac, at, oth, bad);
        checks++; if (rd !== 2 || wr !== 0) begin failures++; $display("FAIL cpu_read_strobes got rd=%0d wr=%0d exp rd=2 wr=0", rd, wr); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL cpu_read_addr got bad=%0d exp=0", bad); end
        checks++; if (ac !== 1 || at !== 3) begin failures++; $display("FAIL cpu_read_ack got n=%0d at=%0d exp n=1 at=3", ac, at); end
        checks++; if (cpu_rdata !== 12'o7402) begin failures++; $display("FAIL cpu_read_data got=%o exp=7402", cpu_rdata); end
        checks++; if (oth !== 0) begin failures++; $display("FAIL cpu_read_dma_done got=%0d exp=0", oth); end
        $display("test_cpu_read addr=07400 rdata=%o ack_at=%0d", cpu_rdata, at);
    endtask

    task automatic test_dma_write();
        int rd, wr, ac, at, oth, bad;
        run_access(1'b1, 1'b1, 1'b0, 15'o10000, 12'o1234, rd, wr, ac, at, oth, bad);
        checks++; if (wr !== 2 || rd !== 0) begin failures++; $display("FAIL dma_write_strobes got rd=%0d wr=%0d exp rd=0 wr=2", rd, wr); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL dma_write_bus got bad=%0d exp=0", bad); end
        checks++; if (ac !== 1 || at !== 3) begin failures++; $display("FAIL dma_write_done got n=%0d at=%0d exp n=1 at=3", ac, at); end
        checks++; if (cpu_rdata !== 12'o7402 || oth !== 0) begin failures++; $display("FAIL dma_write_cpu_side got rdata=%o acks=%0d exp 7402/0", cpu_rdata, oth); end
        checks++; if (mem[15'o10000] !== 12'o1234) begin failures++; $display("FAIL dma_write_mem got=%o exp=1234", mem[15'o10000]); end
        // Read and write requested together must behave as a write
        run_access(1'b1, 1'b1, 1'b1, 15'o10001, 12'o0555, rd, wr, ac, at, oth, bad);
        checks++; if (wr !== 2 || rd !== 0 || mem[15'o10001] !== 12'o0555) begin failures++; $display("FAIL dma_both_is_write got rd=%0d wr=%0d mem=%o exp 0/2/0555", rd, wr, mem[15'o10001]); end
        run_access(1'b1, 1'b0, 1'b0, 15'o10000, 12'o0, rd, wr, ac, at, oth, bad);
        checks++; if (dma_out !== 12'o1234 || rd !== 2) begin failures++; $display("FAIL dma_read_back got=%o rd=%0d exp 1234/2", dma_out, rd); end
        $display("test_dma_write ma=10000 din=1234 done_at=%0d dma_out=%o", at, dma_out);
    endtask

    task automatic test_stale_req();
        int strobes = 0, acks = 0, idle_strobe = 0, ack_k = 0;
        preload(15'o00400, 12'o0444);
        cpu_addr = 15'o00400; cpu_we = 1'b0; cpu_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            if (ram_rd === 1'b1 || ram_wr === 1'b1) strobes++;
            if (ack_k != 0 && k == ack_k + 1) begin
                if (ram_rd !== 1'b0 || ram_wr !== 1'b0) idle_strobe++;
                cpu_req = 1'b0;
            end
            if (cpu_ack === 1'b1) begin acks++; ack_k = k; end
        end
        checks++; if (idle_strobe !== 0) begin failures++; $display("FAIL stale_idle_strobe got=%0d exp=0", idle_strobe); end
        checks++; if (strobes !== 2 || acks !== 1) begin failures++; $display("FAIL stale_regrant got strobes=%0d acks=%0d exp 2/1", strobes, acks); end
        $display("test_stale_req ack_at=%0d strobes=%0d", ack_k, strobes);
    endtask

    task automatic test_addr_hold();
        int bad = 0;
        preload(15'o00200, 12'o0202);
        preload(15'o00300, 12'o0303);
        cpu_addr = 15'o00200; cpu_we = 1'b0; cpu_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            if (k == 1) cpu_addr = 15'o00300;
            if (k <= 3 && ram_addr !== 15'o00200) bad++;
            if (cpu_ack === 1'b1) cpu_req = 1'b0;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL addr_hold_ram_addr got bad=%0d exp=0", bad); end
        checks++; if (cpu_rdata !== 12'o0202) begin failures++; $display("FAIL addr_hold_data got=%o exp=0202", cpu_rdata); end
        $display("test_addr_hold rdata=%o", cpu_rdata);
    endtask

    task automatic test_tie();
        int c1, d1, c2, d2;
        int rd, wr, ac, at, oth, bad;
        preload(15'o00500, 12'o1111);
        preload(15'o00600, 12'o2222);
        pulse_reset();
        run_tie(c1, d1);
        checks++; if (d1 !== 3 || c1 !== 7) begin failures++; $display("FAIL tie1_order got dma_at=%0d cpu_at=%0d exp 3/7", d1, c1); end
        checks++; if (cpu_rdata !== 12'o1111 || dma_out !== 12'o2222) begin failures++; $display("FAIL tie1_data got=%o/%o exp=1111/2222", cpu_rdata, dma_out); end
        run_access(1'b1, 1'b1, 1'b0, 15'o00700, 12'o0123, rd, wr, ac, at, oth, bad);
        run_tie(c2, d2);
`ifdef PDP8_ARB_FAIR_EN
        checks++; if (c2 !== 3 || d2 !== 7) begin failures++; $display("FAIL tie2_order got cpu_at=%0d dma_at=%0d exp 3/7", c2, d2); end
`else
        checks++; if (d2 !== 3 || c2 !== 7) begin failures++; $display("FAIL tie2_order got dma_at=%0d cpu_at=%0d exp 3/7", d2, c2); end
`endif
        $display("test_tie tie1 dma_at=%0d cpu_at=%0d tie2 dma_at=%0d cpu_at=%0d", d1, c1, d2, c2);
    endtask

    task automatic test_reset_mid_access();
        int rd, wr, ac, at, oth, bad;
        int saw_rd = 0;
        cpu_addr = 15'o07400; cpu_we = 1'b0; cpu_req = 1'b1;
        cycle();
        cycle();
        if (ram_rd === 1'b1) saw_rd = 1;
        #2 reset = 1'b1;
        #1;
        checks++; if (saw_rd !== 1) begin failures++; $display("FAIL mid_reset_setup got ram_rd_seen=%0d exp=1", saw_rd); end
        checks++; if (ram_rd !== 1'b0 || ram_wr !== 1'b0 || cpu_ack !== 1'b0 || dma_done !== 1'b0) begin failures++; $display("FAIL mid_reset_strobes got rd=%b wr=%b ack=%b done=%b exp 0000", ram_rd, ram_wr, cpu_ack, dma_done); end
        checks++; if (ram_addr !== 15'd0 || cpu_rdata !== 12'd0) begin failures++; $display("FAIL mid_reset_regs got addr=%o rdata=%o exp 0/0", ram_addr, cpu_rdata); end
        cpu_req = 1'b0;
        cycle();
        reset = 1'b0;
        cycle();
        run_access(1'b0, 1'b0, 1'b0, 15'o07400, 12'o0, rd, wr, ac, at, oth, bad);
        checks++; if (rd !== 2 || ac !== 1 || at !== 3 || cpu_rdata !== 12'o7402) begin failures++; $display("FAIL mid_reset_recover got rd=%0d n=%0d at=%0d rdata=%o exp 2/1/3/7402", rd, ac, at, cpu_rdata); end
        $display("test_reset_mid_access recover ack_at=%0d rdata=%o", at, cpu_rdata);
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_stale_req();
        test_addr_hold();
        test_tie();
        test_reset_mid_access();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pdp8_mem_arbiter.md
Name: pdp8_mem_arbiter

Overview:
- Shares the single pdp8_ram port between two requesters: the CPU (instruction and operand access) and the I/O subsystem's data-break (DMA) channel.
- Sequences each access as a fixed-length RAM cycle, captures read data, and returns a one-cycle completion pulse to the owner.
- Sits between the cpu/io instances and pdp8_ram in top, replacing the direct CPU-to-RAM wiring.

Parameters:
- ADDR_W, 15, memory address width (8 fields x 4K).
- DATA_W, 12, word width.
- ACCESS_CYCLES, 2, cycles ram_rd/ram_wr are held per access; legal range 1..15.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; valid while cpu_req
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  CPU read data; valid from cpu_ack onward
- cpu_ack  out  1  one-cycle completion pulse
- dma_read_req  in  1  DMA read request
- dma_write_req  in  1  DMA write request
- dma_ma  in  ADDR_W  DMA address
- dma_in  in  DATA_W  DMA write data
- dma_out  out  DATA_W  DMA read data
- dma_done  out  1  one-cycle completion pulse
- ram_addr  out  ADDR_W  to pdp8_ram addr
- ram_data_in  out  DATA_W  to pdp8_ram data_in
- ram_data_out  in  DATA_W  from pdp8_ram data_out
- ram_rd  out  1  RAM read strobe
- ram_wr  out  1  RAM write strobe

Behaviour:
- Single clock domain.
- Reset is asynchronous: all outputs go to 0 immediately, state goes to IDLE, the cycle counter clears, the masks clear. No partial access completes.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Evaluates the unmasked requests.
  - If both requesters are pending, DMA wins (data-break priority).
  - On a grant, latches owner, direction, address and write data into registers and moves to ACCESS.
  - No grant leaves all strobes at 0.
- ACCESS:
  - ram_addr and ram_data_in come from the latched registers, never from live inputs.
  - ram_rd or ram_wr is held high for exactly ACCESS_CYCLES cycles.
  - On the last cycle, a read captures ram_data_out into cpu_rdata or dma_out; the other requester's data register holds.
  - Then moves to DONE.
- DONE:
  - Strobes are 0.
  - The owner's ack/done is high for exactly one cycle.
  - Returns to IDLE.
- Latency: request high in an IDLE cycle, then ACCESS_CYCLES strobe cycles, then the ack. Request-to-ack is ACCESS_CYCLES+1 cycles after grant, i.e. 3 with the default.
- Handshake:
  - Requesters hold req and its qualifiers stable until ack and drop req the cycle after.
  - The just-served requester is masked for the first IDLE cycle after DONE, so a stale req is never re-granted.
  - A request arriving during ACCESS or DONE waits. Nothing is lost.
- dma_read_req and dma_write_req both high: treated as a write.
- Input changes after grant have no effect on the access in flight.
- Address is used as-is; there is no wrap or field logic here.
- Read data registers hold their last value until the next read by the same owner.

Optional Feature:
- PDP8_ARB_FAIR_EN, defined:
  - On a simultaneous request, priority goes to the requester not served last. A 1-bit last_owner register resets to CPU, so DMA wins the first tie.
  - Bounds CPU starvation to one DMA access.
- Undefined:
  - Fixed DMA priority on every tie.
  - last_owner is not implemented.

Decomposition:
- Package pdp8_mem_pkg holds:
  - ADDR_W/DATA_W defaults
  - state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2)
  - owner encoding (OWN_CPU=1'b0, OWN_DMA=1'b1)
- One combinational sub-module, pdp8_mem_arb_pick:
  - Inputs: masked requests, plus last_owner under the macro.
  - Outputs: grant valid and grant owner.
  - Kept separate so the fair and fixed policies are unit-testable.

Test Plan:
- CPU read, ACCESS_CYCLES=2, cpu_addr=15'o07400, RAM returns 12'o7402 -> ram_rd high exactly 2 cycles with ram_addr=07400; cpu_ack 3 cycles after grant; cpu_rdata=7402; dma_done stays 0.
- DMA write dma_ma=15'o10000, dma_in=12'o1234 -> ram_wr high 2 cycles, ram_data_in=1234; dma_done single pulse; cpu_rdata unchanged.
- cpu_req and dma_read_req rise the same cycle:
  - Fixed policy: DMA served first, CPU granted on the first IDLE after dma_done.
  - PDP8_ARB_FAIR_EN: the second tie goes to CPU.
- Requester keeps req high one cycle after ack -> no second access is started; ram_rd and ram_wr stay 0 in that IDLE cycle.
- Reset asserted mid-ACCESS -> ram_rd/ram_wr/acks go 0 asynchronously; after release, a new CPU read completes normally with correct data.
- cpu_addr changed during ACCESS from 00200 to 00300 -> ram_addr stays 00200 until DONE.
